// File: rtl/bp_io_loopback_responder.sv
// IO responder for host-only bring-up: serves uncached commands from the FPGA host
// against a scratch register file, a putchar byte FIFO and a getchar input port.
module bp_io_loopback_responder #(
  parameter int                       paddr_width_p      = 40,
  parameter int                       scratch_els_p      = 8,
  parameter logic [paddr_width_p-1:0] scratch_base_p     = 40'h0020_0000,
  parameter logic [paddr_width_p-1:0] putchar_addr_p     = 40'h0010_1000,
  parameter logic [paddr_width_p-1:0] getchar_addr_p     = 40'h0010_0000,
  parameter int                       putchar_fifo_els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_and_o,
  input  logic                     io_cmd_wr_i,
  input  logic [1:0]               io_cmd_size_i,
  input  logic [paddr_width_p-1:0] io_cmd_addr_i,
  input  logic [63:0]              io_cmd_data_i,

  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic                     io_resp_wr_o,
  output logic [1:0]               io_resp_size_o,
  output logic [paddr_width_p-1:0] io_resp_addr_o,
  output logic [63:0]              io_resp_data_o,

  output logic [7:0]               char_o,
  output logic                     char_v_o,
  input  logic                     char_yumi_i,

  input  logic [7:0]               char_i,
  input  logic                     char_v_i,
  output logic                     char_yumi_o,

  output logic                     error_o
);

  localparam int idx_w_lp = $clog2(scratch_els_p);
  localparam int ptr_w_lp = $clog2(putchar_fifo_els_p);
  localparam logic [paddr_width_p-1:0] scratch_bytes_lp = paddr_width_p'(8 * scratch_els_p);
  localparam logic [ptr_w_lp:0]        fifo_full_cnt_lp = (ptr_w_lp + 1)'(putchar_fifo_els_p);

  typedef enum logic [1:0] {e_ready, e_exec, e_resp} state_e;

  state_e state_r, state_n;

  logic                     cmd_wr_r;
  logic [1:0]               cmd_size_r;
  logic [paddr_width_p-1:0] cmd_addr_r;
  logic [63:0]              cmd_data_r;
  logic [63:0]              resp_data_r, resp_data_n;
  logic                     error_r;

  logic [63:0] scratch_r [scratch_els_p];

  logic [7:0]          fifo_mem_r [putchar_fifo_els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_w_lp:0]   count_r;

  logic                     in_exec;
  logic [paddr_width_p-1:0] scratch_off;
  logic                     is_scratch, is_put, is_get, is_unmapped;
  logic [idx_w_lp-1:0]      scratch_idx;
  logic [2:0]               align_mask, byte_off;
  logic [7:0]               size_be, byte_en;
  logic [63:0]              size_dmask, wdata_shifted, rdata;
  logic                     fifo_full, fifo_empty, put_req, push, pop, exec_done;

  assign in_exec     = (state_r == e_exec);
  assign scratch_off = cmd_addr_r - scratch_base_p;
  assign is_scratch  = (cmd_addr_r >= scratch_base_p) && (scratch_off < scratch_bytes_lp);
  assign is_put      = (cmd_addr_r == putchar_addr_p);
  assign is_get      = (cmd_addr_r == getchar_addr_p);
  assign is_unmapped = !is_scratch && !is_put && !is_get;
  assign scratch_idx = scratch_off[3 +: idx_w_lp];

  // Size decides the natural alignment, the byte lanes touched and the read mask
  always_comb begin
    align_mask = 3'b000;
    size_be    = 8'hFF;
    size_dmask = '1;
    case (cmd_size_r)
      2'd0: begin align_mask = 3'b111; size_be = 8'h01; size_dmask = 64'h0000_0000_0000_00FF; end
      2'd1: begin align_mask = 3'b110; size_be = 8'h03; size_dmask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin align_mask = 3'b100; size_be = 8'h0F; size_dmask = 64'h0000_0000_FFFF_FFFF; end
      default: begin align_mask = 3'b000; size_be = 8'hFF; size_dmask = '1; end
    endcase
  end

  assign byte_off      = cmd_addr_r[2:0] & align_mask;
  assign byte_en       = size_be << byte_off;
  assign wdata_shifted = cmd_data_r << {byte_off, 3'b000};
  assign rdata         = (scratch_r[scratch_idx] >> {byte_off, 3'b000}) & size_dmask;

  assign fifo_empty = (count_r == '0);
  assign fifo_full  = (count_r == fifo_full_cnt_lp);
  assign pop        = char_yumi_i && !fifo_empty;
  assign put_req    = in_exec && is_put && cmd_wr_r;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push
  assign push       = put_req && (!fifo_full || pop);
  assign exec_done  = !(put_req && !push);

  always_comb begin
    resp_data_n = '0;
    if (!cmd_wr_r) begin
      if (is_scratch)    resp_data_n = rdata;
      else if (is_get)   resp_data_n = char_v_i ? {56'b0, char_i} : '1;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: if (io_cmd_v_i)     state_n = e_exec;
      e_exec:  if (exec_done)      state_n = e_resp;
      e_resp:  if (io_resp_yumi_i) state_n = e_ready;
      default:                     state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_ready;
      cmd_wr_r    <= 1'b0;
      cmd_size_r  <= '0;
      cmd_addr_r  <= '0;
      cmd_data_r  <= '0;
      resp_data_r <= '0;
      error_r     <= 1'b0;
      for (int i = 0; i < scratch_els_p; i++) scratch_r[i] <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_ready && io_cmd_v_i) begin
        cmd_wr_r   <= io_cmd_wr_i;
        cmd_size_r <= io_cmd_size_i;
        cmd_addr_r <= io_cmd_addr_i;
        cmd_data_r <= io_cmd_data_i;
      end
      if (in_exec && exec_done) resp_data_r <= resp_data_n;
      if (in_exec && is_unmapped) error_r <= 1'b1;
      if (in_exec && is_scratch && cmd_wr_r) begin
        for (int b = 0; b < 8; b++)
          if (byte_en[b]) scratch_r[scratch_idx][8*b +: 8] <= wdata_shifted[8*b +: 8];
      end
    end
  end

  // Putchar FIFO: circular buffer; the head slot keeps its old byte after a pop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < putchar_fifo_els_p; i++) fifo_mem_r[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem_r[wr_ptr_r] <= cmd_data_r[7:0];
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end
      if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Ready is masked by reset so every output reads 0 while reset is held
  assign io_cmd_ready_and_o = (state_r == e_ready) && reset_n_i;
  assign io_resp_v_o        = (state_r == e_resp);
  assign io_resp_wr_o       = cmd_wr_r;
  assign io_resp_size_o     = cmd_size_r;
  assign io_resp_addr_o     = cmd_addr_r;
  assign io_resp_data_o     = resp_data_r;
  assign char_o             = fifo_mem_r[rd_ptr_r];
  assign char_v_o           = !fifo_empty;
  assign char_yumi_o        = in_exec && is_get && !cmd_wr_r && char_v_i;
  assign error_o            = error_r;

endmodule

// File: doc/bp_io_loopback_responder.md
Name: bp_io_loopback_responder

Overview:
- BedRock-style IO responder at the far end of the FPGA host's outgoing IO command channel.
- Accepts uncached read/write commands from bp_fpga_host and returns one response per command.
- Backs a small scratch register file, a putchar byte FIFO drained to a char output port, and a non-blocking getchar byte input port.
- Stands in for the BlackParrot IO side in host-only FPGA bring-up.

Parameters:
- paddr_width_p, 40, physical address width.
- scratch_els_p, 8, number of 64-bit scratch registers (power of 2, 2..64).
- scratch_base_p, 40'h0020_0000, byte base address of the scratch region.
- putchar_addr_p, 40'h0010_1000, putchar address.
- getchar_addr_p, 40'h0010_0000, getchar address.
- putchar_fifo_els_p, 4, putchar FIFO depth (power of 2, >=2).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous assert, active low
- io_cmd_v_i  in  1  command valid
- io_cmd_ready_and_o  out  1  command ready; transfer when v & ready_and
- io_cmd_wr_i  in  1  1 = uc write, 0 = uc read
- io_cmd_size_i  in  2  log2 of bytes (0:1B, 1:2B, 2:4B, 3:8B)
- io_cmd_addr_i  in  paddr_width_p  byte address
- io_cmd_data_i  in  64  write data, value in LSBs
- io_resp_v_o  out  1  response valid
- io_resp_yumi_i  in  1  response consumed; legal only while io_resp_v_o is high
- io_resp_wr_o / io_resp_size_o / io_resp_addr_o  out  1/2/paddr_width_p  echo of the accepted command header
- io_resp_data_o  out  64  read data in LSBs, zero-extended; 0 for writes
- char_o  out  8  putchar byte at FIFO head
- char_v_o  out  1  FIFO not empty
- char_yumi_i  in  1  pops FIFO head
- char_i  in  8  getchar byte
- char_v_i  in  1  getchar byte available
- char_yumi_o  out  1  consumes char_i
- error_o  out  1  sticky; set on access to an unmapped address

Behaviour:
- Async reset (reset_n_i low):
  - All outputs 0; state e_ready; FIFO empty.
  - scratch registers 0; error_o 0.
  - In-flight command and response are discarded, with no partial scratch write.
- FSM e_ready -> e_exec -> e_resp -> e_ready.
- e_ready:
  - io_cmd_ready_and_o = 1.
  - On v & ready_and, latch the header and data; go to e_exec.
- e_exec: decode the latched address.
  - Scratch hit: addr in [scratch_base_p, scratch_base_p + 8*scratch_els_p). Index = (addr - base) >> 3. Offset = addr[2:0] rounded down to 2^size alignment.
    - Write: merge the low 2^size bytes of data at that offset.
    - Read: return those bytes shifted to the LSBs, zero-extended.
  - Putchar write: push data[7:0] if the FIFO is not full. If full, stay in e_exec (stall) until a pop frees space; the push happens that cycle. Putchar read returns 0.
  - Getchar read:
    - If char_v_i, return {56'b0, char_i} and assert char_yumi_o for exactly this cycle.
    - Else return 64'hFFFF_FFFF_FFFF_FFFF.
    - Getchar write is ignored.
  - Unmapped: write dropped; read returns 0; error_o set and held until reset.
  - Go to e_resp once the action completes.
- e_resp:
  - io_resp_v_o = 1 with registered header and data, held stable until io_resp_yumi_i.
  - On yumi go to e_ready; the next command is accepted no earlier than the following cycle.
- Latency: command accepted in cycle N -> io_resp_v_o rises in cycle N+2 (longer only on putchar stall). Throughput is 1 command per 3 cycles.
- FIFO:
  - Circular with wrapping read and write pointers plus a count.
  - Push and pop in the same cycle is allowed; when full, a pop and a push in the same e_exec cycle succeed together.
  - char_yumi_i while empty is ignored.
  - char_o is undefined-but-stable (hold last value) while empty.
- Only one command is outstanding at any time; io_cmd_v_i during e_exec or e_resp is not acknowledged.

Test Plan:
- 8B write 0x1122334455667788 to scratch_base_p+8, then 8B read of the same address -> io_resp_data_o = 0x1122334455667788; resp addr/size echo the command; response 2 cycles after acceptance.
- 1B write 0xAB to scratch_base_p+13, then 8B read of scratch_base_p+8 -> 0x1122AB4455667788; 2B read at +12 -> 0x000000000000AB44.
- Five putchar writes 'a'..'e' with char_yumi_i low -> four responses; fifth stalls in e_exec with no io_resp_v_o. Pulse char_yumi_i once -> fifth response issues. Drain -> bytes pop in order 'a','b','c','d','e'.
- Getchar read with char_v_i=0 -> data 0xFFFFFFFFFFFFFFFF, char_yumi_o never high. With char_v_i=1, char_i=0x5A -> data 0x5A, char_yumi_o high for 1 cycle.
- Read of address 0x0030_0000 -> data 0, error_o = 1 and remains 1 across later valid accesses.
- Deassert reset_n_i while in e_resp holding a scratch read -> io_resp_v_o drops immediately, scratch and FIFO cleared, error_o 0. After release, the first command is accepted in e_ready.
